jt12_snd_mix: RTL and testbench

JT12_SND_MIX -- requirements
Module: jt12_snd_mix

---
 rtl/jt12_mix_pkg.sv | 17 +
 rtl/jt12_mix_sat.sv | 43 ++++
 rtl/jt12_snd_mix.sv | 174 +++++++++++++++++
 tb/tb_jt12_snd_mix.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_mix_pkg.sv
// jt12_mix_pkg
// Shared definitions for the sound mixer:
//   mix_state_e - mixer sequencing states (IDLE / ACC / OUT)
//   UNITY_GAIN  - gain register value meaning x1.0
//   FRAC_BITS   - number of fraction bits in a gain value
package jt12_mix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } mix_state_e;

    localparam int FRAC_BITS  = 4;
    localparam int UNITY_GAIN = 16;   // 0x10 = 1.0 with four fraction bits

endpackage

// File: rtl/jt12_mix_sat.sv
// jt12_mix_sat
// Combinational signed saturator: clamps an IW-bit signed value into
// OW bits and flags when the clamp was applied.
// Ports:
//   din  in  IW  signed value to be narrowed
//   dout out OW  clamped result
//   ovf  out 1   high when din lay outside the OW-bit range
module jt12_mix_sat #(
    parameter int IW = 27,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 ovf
);

    generate
        if (IW > OW) begin : g_narrow
            // Range limits expressed at the input width for a plain signed compare
            localparam logic signed [IW-1:0] MAX_V = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
            localparam logic signed [IW-1:0] MIN_V = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

            always_comb begin
                dout = din[OW-1:0];
                ovf  = 1'b0;
                if (din > MAX_V) begin
                    dout = {1'b0, {(OW-1){1'b1}}};
                    ovf  = 1'b1;
                end else if (din < MIN_V) begin
                    dout = {1'b1, {(OW-1){1'b0}}};
                    ovf  = 1'b1;
                end
            end
        end else begin : g_wide
            // Output is at least as wide as the input: sign-extend, never clamps
            always_comb begin
                dout = OW'(din);
                ovf  = 1'b0;
            end
        end
    endgenerate

endmodule

// File: rtl/jt12_snd_mix.sv
// jt12_snd_mix
// Time-multiplexed gain mixer. On a sample strobe the CH inputs and the
// CH gains are captured, then one shared signed x unsigned multiplier
// accumulates one channel per cen cycle; the sum is scaled by the gain
// fraction bits and saturated to OW bits.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cen             clock enable; nothing advances while low
//   snd_in          CH packed signed W-bit samples (channel k at [k*W +: W])
//   sample          input sample strobe
//   gain_we/addr/din gain register write port (addr >= CH ignored)
//   mix             registered saturated mix
//   mix_sample      one-cen-cycle pulse when mix updates
//   busy            high while a mix is in progress
//   clip, overrun   sticky flags, cleared by clr_flags
module jt12_snd_mix
    import jt12_mix_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = 16,
    parameter int GW = 8,
    parameter int OW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    input  logic [CH*W-1:0]      snd_in,
    input  logic                 sample,
    input  logic                 gain_we,
    input  logic [3:0]           gain_addr,
    input  logic [GW-1:0]        gain_din,
    output logic signed [OW-1:0] mix,
    output logic                 mix_sample,
    output logic                 busy,
    output logic                 clip,
    output logic                 overrun,
    input  logic                 clr_flags
);

    localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW    = W + GW + 1;             // product width
    localparam int AW    = W + GW + 1 + $clog2(CH); // accumulator width

    mix_state_e               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [AW-1:0]     acc_q, acc_d;
    logic signed [OW-1:0]     mix_q, mix_d;
    logic                     mix_sample_q, mix_sample_d;
    logic                     clip_q, clip_d;
    logic                     overrun_q, overrun_d;
    logic [CH*W-1:0]          snd_q, snd_d;
    logic [GW-1:0]            gain_q   [CH];
    logic [GW-1:0]            gain_d   [CH];
    logic [GW-1:0]            shadow_q [CH];
    logic [GW-1:0]            shadow_d [CH];

    // Single shared multiplier fed by the channel selected with idx
    logic signed [W-1:0]      snd_sel;
    logic [GW-1:0]            gain_sel;
    logic signed [PW-1:0]     prod;
    logic signed [AW-1:0]     acc_scaled;
    logic signed [OW-1:0]     sat_out;
    logic                     sat_ovf;

    assign snd_sel    = snd_q[idx_q*W +: W];
    assign gain_sel   = shadow_q[idx_q];
    // Zero-extend the gain so the product is signed x unsigned
    assign prod       = snd_sel * $signed({1'b0, gain_sel});
    assign acc_scaled = acc_q >>> FRAC_BITS;

    jt12_mix_sat #(
        .IW (AW),
        .OW (OW)
    ) u_sat (
        .din  (acc_scaled),
        .dout (sat_out),
        .ovf  (sat_ovf)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        mix_d        = mix_q;
        mix_sample_d = mix_sample_q;
        clip_d       = clip_q;
        overrun_d    = overrun_q;
        snd_d        = snd_q;
        gain_d       = gain_q;
        shadow_d     = shadow_q;

        if (cen) begin
            mix_sample_d = 1'b0;

            if (gain_we && (int'(gain_addr) < CH))
                gain_d[gain_addr[IDX_W-1:0]] = gain_din;

            unique case (state_q)
                ST_IDLE: begin
                    if (sample) begin
                        // Shadow takes the pre-write gains, so a write in this
                        // same cycle only affects later mixes
                        snd_d    = snd_in;
                        shadow_d = gain_q;
                        acc_d    = '0;
                        idx_d    = '0;
                        state_d  = ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc_d = acc_q + AW'(prod);
                    if (idx_q == IDX_W'(CH - 1)) begin
                        idx_d   = '0;
                        state_d = ST_OUT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                ST_OUT: begin
                    mix_d        = sat_out;
                    mix_sample_d = 1'b1;
                    if (sat_ovf)
                        clip_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (sample && (state_q != ST_IDLE))
                overrun_d = 1'b1;

            // Clearing wins over a set in the same cycle
            if (clr_flags) begin
                clip_d    = 1'b0;
                overrun_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            mix_q        <= '0;
            mix_sample_q <= 1'b0;
            clip_q       <= 1'b0;
            overrun_q    <= 1'b0;
            snd_q        <= '0;
            for (int i = 0; i < CH; i++) begin
                gain_q[i]   <= GW'(UNITY_GAIN);
                shadow_q[i] <= GW'(UNITY_GAIN);
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            mix_q        <= mix_d;
            mix_sample_q <= mix_sample_d;
            clip_q       <= clip_d;
            overrun_q    <= overrun_d;
            snd_q        <= snd_d;
            gain_q       <= gain_d;
            shadow_q     <= shadow_d;
        end
    end

    assign mix        = mix_q;
    assign mix_sample = mix_sample_q;
    assign busy       = (state_q != ST_IDLE);
    assign clip       = clip_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_jt12_snd_mix.sv
// tb_jt12_snd_mix
// Directed bench: the driver pushes the hand-computed mix for each strobe
// into a scoreboard; a monitor pops and compares on each mix_sample pulse.
module tb_jt12_snd_mix;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int GW = 8;
    localparam int OW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cen = 1'b1;
    logic [CH*W-1:0]      snd_in = '0;
    logic                 sample = 1'b0;
    logic                 gain_we = 1'b0;
    logic [3:0]           gain_addr = '0;
    logic [GW-1:0]        gain_din = '0;
    logic signed [OW-1:0] mix;
    logic                 mix_sample;
    logic                 busy;
    logic                 clip;
    logic                 overrun;
    logic                 clr_flags = 1'b0;

    jt12_snd_mix #(.CH(CH), .W(W), .GW(GW), .OW(OW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cen        (cen),
        .snd_in     (snd_in),
        .sample     (sample),
        .gain_we    (gain_we),
        .gain_addr  (gain_addr),
        .gain_din   (gain_din),
        .mix        (mix),
        .mix_sample (mix_sample),
        .busy       (busy),
        .clip       (clip),
        .overrun    (overrun),
        .clr_flags  (clr_flags)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int val;
        int start;
    } exp_t;

    exp_t sb[$];
    int   n_run = 0;
    int   n_fail = 0;
    int   cen_edges = 0;
    int   pulse_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Count active cen edges so latency is measured in cen cycles
    initial forever begin
        @(posedge clk);
        if (cen && rst_n) cen_edges++;
    end

    // Monitor: one compare set per new mix_sample pulse
    initial begin
        logic ms_prev;
        exp_t e;
        ms_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && mix_sample && !ms_prev) begin
                pulse_cnt++;
                if (sb.size() == 0) begin
                    n_run++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_pulse: got mix=%0d, expected no pulse", mix);
                end else begin
                    e = sb.pop_front();
                    $display("[TB] mix pulse: mix=%0d expected=%0d latency=%0d",
                             mix, e.val, cen_edges - e.start - 1);
                    check("mix_value", int'(mix), e.val);
                    check("latency", cen_edges - e.start - 1, CH + 1);
                end
            end
            ms_prev = mix_sample;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_in(input int a0, input int a1, input int a2, input int a3);
        snd_in = {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
    endtask

    task automatic write_gain(input int addr, input int val);
        gain_we   = 1'b1;
        gain_addr = addr[3:0];
        gain_din  = val[GW-1:0];
        step();
        gain_we   = 1'b0;
    endtask

    task automatic strobe(input int expv);
        exp_t e;
        e.val   = expv;
        e.start = cen_edges;
        sb.push_back(e);
        sample = 1'b1;
        step();
        sample = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
        step();
    endtask

    task automatic clear_flags();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
    endtask

    initial begin
        int pc;
        int n;

        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset state
        check("rst_mix", int'(mix), 0);
        check("rst_mix_sample", int'(mix_sample), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_clip", int'(clip), 0);
        check("rst_overrun", int'(overrun), 0);

        // Unity gains: 100+200-50+25
        set_in(100, 200, -50, 25);
        strobe(275);
        check("busy_in_acc", int'(busy), 1);
        wait_idle();
        check("clip_after_unity", int'(clip), 0);

        // Positive saturation: 0x4000 * 2.0 = 32768 -> 32767
        write_gain(0, 'h20);
        write_gain(1, 0);
        write_gain(2, 0);
        write_gain(3, 0);
        set_in('h4000, 1234, -999, 77);
        strobe(32767);
        wait_idle();
        check("clip_set_pos", int'(clip), 1);
        clear_flags();
        check("clip_cleared", int'(clip), 0);

        // Half gain on channel 1: -1000 * 0.5
        write_gain(0, 0);
        write_gain(1, 'h08);
        set_in(3000, -1000, 5, -5);
        strobe(-500);
        wait_idle();
        check("clip_half_gain", int'(clip), 0);

        // Negative saturation: -32768 * 255/16 -> -32768
        write_gain(1, 'hFF);
        set_in(0, -32768, 0, 0);
        strobe(-32768);
        wait_idle();
        check("clip_set_neg", int'(clip), 1);
        clear_flags();

        // Overrun: second strobe two cycles after the first is dropped
        for (int i = 0; i < CH; i++) write_gain(i, 'h10);
        set_in(100, 200, -50, 25);
        pc = pulse_cnt;
        strobe(275);
        step();
        sample = 1'b1;
        step();
        sample = 1'b0;
        wait_idle();
        repeat (10) step();
        check("overrun_set", int'(overrun), 1);
        check("overrun_single_pulse", pulse_cnt - pc, 1);
        check("overrun_mix_kept", int'(mix), 275);

        // clr_flags wins over a same-cycle overrun set
        set_in(1, 2, 3, 4);
        strobe(10);
        clr_flags = 1'b1;
        sample = 1'b1;
        step();
        sample = 1'b0;
        clr_flags = 1'b0;
        check("clr_priority", int'(overrun), 0);
        wait_idle();

        // Gain write mid-mix uses old gain now, new gain next time
        set_in(1000, 0, 0, 0);
        strobe(1000);
        write_gain(0, 'h20);
        wait_idle();
        strobe(2000);
        wait_idle();
        write_gain(CH, 0);
        strobe(2000);
        wait_idle();

        // Reset during ACC aborts the mix
        pc = pulse_cnt;
        sample = 1'b1;
        step();
        sample = 1'b0;
        step();
        sample = 1'b1;
        step();
        sample = 1'b0;
        check("pre_rst_overrun", int'(overrun), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_mix", int'(mix), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_overrun", int'(overrun), 0);
        check("midrst_mix_sample", int'(mix_sample), 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        check("midrst_no_pulse", pulse_cnt - pc, 0);
        // Gains back to unity after reset: 1000 * 1.0
        strobe(1000);
        wait_idle();

        // cen held low for 10 cycles mid-mix
        set_in(100, 200, -50, 25);
        strobe(275);
        step();
        cen = 1'b0;
        repeat (10) step();
        check("busy_hold_cen0", int'(busy), 1);
        cen = 1'b1;
        wait_idle();

        // mix_sample stays high while cen is low
        set_in(-100, -200, 50, -25);
        strobe(-275);
        n = 0;
        while (!mix_sample && n < 50) begin
            step();
            n++;
        end
        check("pulse_seen", int'(mix_sample), 1);
        cen = 1'b0;
        repeat (3) step();
        check("mix_sample_hold", int'(mix_sample), 1);
        cen = 1'b1;
        step();
        check("mix_sample_drop", int'(mix_sample), 0);

        repeat (5) step();
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
